// File: rtl/fragment_sink.sv
`default_nettype none
// ============================================================================
//  Module      : fragment_sink
//  Description : Deserializes the rasterizer's three MSB-first serial lanes
//                (X, Y in signed Q10.6, RGB565 colour), converts coordinates
//                to integer pixel indices, clips against the screen and
//                issues linear-address framebuffer writes over ready/valid.
//                Also turns TRI_DONE into a TRI_ACK that waits for all of
//                that triangle's writes to drain.
//  Revision    : 1.0 - initial release
// ============================================================================
module fragment_sink #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int FRAC   = 6,
  parameter int AW     = 17
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          PX,
  input  logic          PY,
  input  logic          C,
  input  logic          WSTART,
  input  logic          INSIDE,
  input  logic          TRI_DONE,
  input  logic          FB_READY,
  output logic          FB_WE,
  output logic [AW-1:0] FB_ADDR,
  output logic [15:0]   FB_DATA,
  output logic          TRI_ACK,
  output logic          CLIPPED,
  output logic          OVERFLOW,
  output logic [19:0]   PIX_COUNT
);

  localparam logic [15:0]   c_width16  = 16'(WIDTH);
  localparam logic [15:0]   c_height16 = 16'(HEIGHT);
  localparam logic [AW-1:0] c_width_aw = AW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_WR   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Deserializer: the top 15 bits live here, bit 0 comes straight off the lane
  logic [14:0] r_sx;
  logic [14:0] r_sy;
  logic [14:0] r_sc;
  logic [3:0]  r_k;
  logic        r_active;
  logic        r_inside;

  // Word captured by the writer
  logic [15:0] r_wx;
  logic [15:0] r_wy;
  logic [15:0] r_wc;

  logic        r_tri_pend;

  logic          w_complete;
  logic          w_take;
  logic          w_drop;
  logic [15:0]   w_x;
  logic [15:0]   w_y;
  logic          w_clip;
  logic [AW-1:0] w_addr;

  // A word completes when bit 0 is shifted in without a restart in that cycle
  assign w_complete = r_active && !WSTART && (r_k == 4'd14);
  // Handover uses the registered writer state only, no look-ahead
  assign w_take     = w_complete && r_inside && (r_state == S_IDLE);
  assign w_drop     = w_complete && r_inside && (r_state != S_IDLE);

  // Floor-convert Q10.6 to integer pixel index; negatives show up in bit 15
  assign w_x    = 16'($signed(r_wx) >>> FRAC);
  assign w_y    = 16'($signed(r_wy) >>> FRAC);
  assign w_clip = w_x[15] || w_y[15] || (w_x >= c_width16) || (w_y >= c_height16);
  assign w_addr = AW'(w_y) * c_width_aw + AW'(w_x);

  // Serial capture of the three lanes and the bit counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sx     <= '0;
      r_sy     <= '0;
      r_sc     <= '0;
      r_k      <= '0;
      r_active <= 1'b0;
      r_inside <= 1'b0;
    end else if (WSTART) begin
      r_sx     <= {14'd0, PX};
      r_sy     <= {14'd0, PY};
      r_sc     <= {14'd0, C};
      r_k      <= 4'd0;
      r_active <= 1'b1;
      r_inside <= INSIDE;
    end else if (r_active) begin
      r_sx     <= {r_sx[13:0], PX};
      r_sy     <= {r_sy[13:0], PY};
      r_sc     <= {r_sc[13:0], C};
      r_k      <= r_k + 4'd1;
      if (w_complete) begin
        r_active <= 1'b0;
      end
    end
  end

  // Writer state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Writer next-state and combinational outputs
  always_comb begin
    w_state_nxt = r_state;
    FB_WE       = 1'b0;
    TRI_ACK     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        w_state_nxt = w_clip ? S_IDLE : S_WR;
      end
      S_WR: begin
        FB_WE = 1'b1;
        if (FB_READY) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Acknowledge only once nothing of the triangle is still in flight
    TRI_ACK = r_tri_pend && !r_active && (r_state == S_IDLE);
  end

  // Writer datapath: word capture, address/data registers, clip pulse, counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wx      <= '0;
      r_wy      <= '0;
      r_wc      <= '0;
      FB_ADDR   <= '0;
      FB_DATA   <= '0;
      CLIPPED   <= 1'b0;
      PIX_COUNT <= '0;
    end else begin
      CLIPPED <= 1'b0;
      if (w_take) begin
        r_wx <= {r_sx, PX};
        r_wy <= {r_sy, PY};
        r_wc <= {r_sc, C};
      end
      if (r_state == S_CONV) begin
        if (w_clip) begin
          CLIPPED <= 1'b1;
        end else begin
          FB_ADDR <= w_addr;
          FB_DATA <= r_wc;
        end
      end
      if ((r_state == S_WR) && FB_READY) begin
        PIX_COUNT <= PIX_COUNT + 20'd1;
      end
    end
  end

  // Sticky overflow and pending triangle-done flag (repeat pulses merge)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVERFLOW   <= 1'b0;
      r_tri_pend <= 1'b0;
    end else begin
      if (w_drop) begin
        OVERFLOW <= 1'b1;
      end
      if (TRI_ACK) begin
        r_tri_pend <= 1'b0;
      end else if (TRI_DONE) begin
        r_tri_pend <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fragment_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fragment_sink
//  Description : Directed and randomized self-checking bench for
//                fragment_sink with a floor-division reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fragment_sink;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PX = 1'b0;
  logic        PY = 1'b0;
  logic        C = 1'b0;
  logic        WSTART = 1'b0;
  logic        INSIDE = 1'b0;
  logic        TRI_DONE = 1'b0;
  logic        FB_READY = 1'b1;
  logic        FB_WE;
  logic [16:0] FB_ADDR;
  logic [15:0] FB_DATA;
  logic        TRI_ACK;
  logic        CLIPPED;
  logic        OVERFLOW;
  logic [19:0] PIX_COUNT;

  int checks = 0;
  int errors = 0;

  fragment_sink #(.WIDTH(320), .HEIGHT(240), .FRAC(6), .AW(17)) dut (
    .CLK(CLK), .RST(RST), .PX(PX), .PY(PY), .C(C), .WSTART(WSTART),
    .INSIDE(INSIDE), .TRI_DONE(TRI_DONE), .FB_READY(FB_READY),
    .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .TRI_ACK(TRI_ACK),
    .CLIPPED(CLIPPED), .OVERFLOW(OVERFLOW), .PIX_COUNT(PIX_COUNT)
  );

  always #5 CLK = ~CLK;

  // Cycle counter and negedge monitor of accepted writes, clips and acks
  int          cyc = 0;
  logic [16:0] got_addr [0:4095];
  logic [15:0] got_data [0:4095];
  int          got_n = 0;
  int          clip_cnt = 0;
  int          ack_cnt = 0;
  int          acc_cyc = 0;
  int          ack_cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (FB_WE === 1'b1 && FB_READY === 1'b1 && RST === 1'b0) begin
      got_addr[got_n] <= FB_ADDR;
      got_data[got_n] <= FB_DATA;
      got_n           <= got_n + 1;
      acc_cyc         <= cyc;
    end
    if (CLIPPED === 1'b1) clip_cnt <= clip_cnt + 1;
    if (TRI_ACK === 1'b1) begin
      ack_cnt <= ack_cnt + 1;
      ack_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive nbits serial bits starting from bit 15; tri pulses with bit 0
  task automatic send_word(input logic [15:0] px, input logic [15:0] py,
                           input logic [15:0] c, input logic ins,
                           input logic tri_last, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      int b;
      b        = 15 - i;
      WSTART   = (i == 0);
      INSIDE   = (i == 0) ? ins : 1'b0;
      PX       = px[b];
      PY       = py[b];
      C        = c[b];
      TRI_DONE = tri_last && (b == 0);
      tick();
    end
    WSTART   = 1'b0;
    INSIDE   = 1'b0;
    TRI_DONE = 1'b0;
    PX       = 1'b0;
    PY       = 1'b0;
    C        = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  // Reference: floor-divide the fixed-point value by 64 and bounds-check
  function automatic int floor64(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    return (s >= 0) ? s / 64 : -((-s + 63) / 64);
  endfunction

  function automatic bit ref_clip(input logic [15:0] px, input logic [15:0] py);
    int x, y;
    x = floor64(px);
    y = floor64(py);
    return (x < 0) || (x >= 320) || (y < 0) || (y >= 240);
  endfunction

  function automatic int ref_addr(input logic [15:0] px, input logic [15:0] py);
    return floor64(py) * 320 + floor64(px);
  endfunction

  initial begin
    int w0, c0, a0, rd, nexp, nclip;
    int exp_addr[$];
    int exp_data[$];

    // Reset values
    #2;
    check("rst_we", 32'(FB_WE), 0);
    check("rst_addr", 32'(FB_ADDR), 0);
    check("rst_data", 32'(FB_DATA), 0);
    check("rst_ack", 32'(TRI_ACK), 0);
    check("rst_clip", 32'(CLIPPED), 0);
    check("rst_ovf", 32'(OVERFLOW), 0);
    check("rst_cnt", 32'(PIX_COUNT), 0);
    tick();
    RST = 1'b0;
    tick();

    // Single pixel (5,3) -> 965
    send_word(16'h0140, 16'h00C0, 16'hF800, 1'b1, 1'b0, 16);
    check("sp_we_conv", 32'(FB_WE), 0);
    tick();
    check("sp_we", 32'(FB_WE), 1);
    check("sp_addr", 32'(FB_ADDR), 32'(ref_addr(16'h0140, 16'h00C0)));
    check("sp_data", 32'(FB_DATA), 32'hF800);
    tick();
    check("sp_we_drop", 32'(FB_WE), 0);
    check("sp_cnt", 32'(PIX_COUNT), 1);

    // Backpressure: second word dropped while first write is stalled
    do_reset();
    FB_READY = 1'b0;
    w0 = got_n;
    send_word(16'h0140, 16'h00C0, 16'h1234, 1'b1, 1'b0, 16);
    send_word(16'h0280, 16'h0040, 16'h4321, 1'b1, 1'b0, 16);
    check("bp_we_held", 32'(FB_WE), 1);
    check("bp_addr_held", 32'(FB_ADDR), 965);
    check("bp_data_held", 32'(FB_DATA), 32'h1234);
    check("bp_ovf", 32'(OVERFLOW), 1);
    tick(); tick(); tick();
    FB_READY = 1'b1;
    tick();
    check("bp_we_drop", 32'(FB_WE), 0);
    check("bp_cnt", 32'(PIX_COUNT), 1);
    for (int i = 0; i < 20; i++) tick();
    check("bp_cnt_final", 32'(PIX_COUNT), 1);
    check("bp_ovf_sticky", 32'(OVERFLOW), 1);
    check("bp_writes", 32'(got_n - w0), 1);

    // Clipping and far-corner pixel
    do_reset();
    c0 = clip_cnt;
    send_word(16'hFFC0, 16'h00C0, 16'h1111, 1'b1, 1'b0, 16);
    tick();
    check("clip_neg", 32'(CLIPPED), 1);
    check("clip_neg_we", 32'(FB_WE), 0);
    tick();
    check("clip_pulse_end", 32'(CLIPPED), 0);
    send_word(16'h5000, 16'h00C0, 16'h2222, 1'b1, 1'b0, 16);
    tick();
    check("clip_wide", 32'(CLIPPED), 1);
    send_word(16'h4FC0, 16'h3BC0, 16'hABCD, 1'b1, 1'b0, 16);
    tick();
    check("corner_we", 32'(FB_WE), 1);
    check("corner_addr", 32'(FB_ADDR), 76799);
    check("corner_data", 32'(FB_DATA), 32'hABCD);
    tick();
    check("corner_cnt", 32'(PIX_COUNT), 1);
    check("clip_count", 32'(clip_cnt - c0), 2);

    // Outside word, restart at k=7, then origin word
    do_reset();
    w0 = got_n;
    c0 = clip_cnt;
    send_word(16'h0140, 16'h00C0, 16'h5555, 1'b0, 1'b0, 16);
    send_word(16'h0140, 16'h0140, 16'h7777, 1'b1, 1'b0, 7);
    send_word(16'h0000, 16'h0000, 16'h0F0F, 1'b1, 1'b0, 16);
    for (int i = 0; i < 4; i++) tick();
    check("rs_writes", 32'(got_n - w0), 1);
    check("rs_addr", 32'(got_addr[w0]), 0);
    check("rs_data", 32'(got_data[w0]), 32'h0F0F);
    check("rs_noclip", 32'(clip_cnt - c0), 0);
    check("rs_noovf", 32'(OVERFLOW), 0);

    // TRI_DONE on last bit with 4 stalled cycles
    do_reset();
    a0 = ack_cnt;
    FB_READY = 1'b0;
    send_word(16'h0140, 16'h00C0, 16'h00FF, 1'b1, 1'b1, 16);
    for (int i = 0; i < 5; i++) tick();
    check("tri_no_early_ack", 32'(ack_cnt - a0), 0);
    check("tri_we_stalled", 32'(FB_WE), 1);
    FB_READY = 1'b1;
    tick();
    check("tri_ack_now", 32'(TRI_ACK), 1);
    tick();
    check("tri_ack_pulse", 32'(TRI_ACK), 0);
    tick();
    check("tri_ack_once", 32'(ack_cnt - a0), 1);
    check("tri_ack_after_acc", 32'(ack_cyc > acc_cyc), 1);
    // Second TRI_DONE while pending merges into one acknowledge
    send_word(16'h0140, 16'h00C0, 16'h00FE, 1'b1, 1'b1, 16);
    TRI_DONE = 1'b1;
    tick();
    TRI_DONE = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("tri_merge", 32'(ack_cnt - a0), 2);

    // Reset mid-write: write lost, no acknowledge
    do_reset();
    a0 = ack_cnt;
    w0 = got_n;
    FB_READY = 1'b0;
    send_word(16'h0140, 16'h00C0, 16'h3333, 1'b1, 1'b1, 16);
    tick();
    check("mw_we", 32'(FB_WE), 1);
    #2;
    RST = 1'b1;
    #1;
    check("mw_async_drop", 32'(FB_WE), 0);
    FB_READY = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mw_no_ack", 32'(ack_cnt - a0), 0);
    check("mw_no_write", 32'(got_n - w0), 0);

    // Reset at k=9, then a fresh word
    send_word(16'h0140, 16'h00C0, 16'h4444, 1'b1, 1'b0, 9);
    PX = 1'b1;
    RST = 1'b1;
    #1;
    check("k9_we", 32'(FB_WE), 0);
    check("k9_addr", 32'(FB_ADDR), 0);
    check("k9_data", 32'(FB_DATA), 0);
    check("k9_ack", 32'(TRI_ACK), 0);
    check("k9_clip", 32'(CLIPPED), 0);
    check("k9_ovf", 32'(OVERFLOW), 0);
    check("k9_cnt", 32'(PIX_COUNT), 0);
    PX = 1'b0;
    tick(); tick();
    RST = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) tick();
    check("k9_no_write", 32'(got_n - w0), 0);
    send_word(16'h0280, 16'h0040, 16'hBEEF, 1'b1, 1'b0, 16);
    tick();
    check("k9_fresh_we", 32'(FB_WE), 1);
    check("k9_fresh_addr", 32'(FB_ADDR), 330);
    check("k9_fresh_data", 32'(FB_DATA), 32'hBEEF);
    tick();
    check("k9_fresh_cnt", 32'(PIX_COUNT), 1);

    // Randomized words against the reference model
    do_reset();
    w0 = got_n;
    c0 = clip_cnt;
    nclip = 0;
    for (int n = 0; n < 40; n++) begin
      logic [15:0] px, py, cc;
      logic ins;
      px  = 16'(int'($urandom_range(0, 22400)) - 640);
      py  = 16'(int'($urandom_range(0, 16000)) - 640);
      cc  = 16'($urandom);
      ins = ($urandom_range(0, 3) != 0);
      if (ins) begin
        if (ref_clip(px, py)) begin
          nclip++;
        end else begin
          exp_addr.push_back(ref_addr(px, py));
          exp_data.push_back(int'(cc));
        end
      end
      send_word(px, py, cc, ins, 1'b0, 16);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
    end
    for (int i = 0; i < 6; i++) tick();
    nexp = exp_addr.size();
    check("rnd_nwrites", 32'(got_n - w0), 32'(nexp));
    check("rnd_nclip", 32'(clip_cnt - c0), 32'(nclip));
    check("rnd_cnt", 32'(PIX_COUNT), 32'(nexp));
    check("rnd_noovf", 32'(OVERFLOW), 0);
    rd = w0;
    for (int i = 0; i < nexp; i++) begin
      if (rd < got_n) begin
        check("rnd_addr", 32'(got_addr[rd]), 32'(exp_addr[i]));
        check("rnd_data", 32'(got_data[rd]), 32'(exp_data[i]));
        rd++;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
